// File: rtl/mac_se_fb_pkg.sv
// Shared definitions for the Mac SE frame-buffer arbiter and the capture writer.
// Holds the RAM geometry, the display-line geometry, the write-slot spacing,
// the arbiter FSM state encoding and a helper that forms a RAM word address
// from a line number and a word index.
package mac_se_fb_pkg;

  localparam int DATA_W         = 16;
  localparam int ADDR_W         = 14;
  localparam int WORDS_PER_LINE = 32;
  localparam int WORD_W         = $clog2(WORDS_PER_LINE);
  localparam int LINE_W         = 9;
  localparam int FB_LINES       = 342;
  localparam int WR_SLOT_EVERY  = 4;
  localparam int RUN_W          = $clog2(WR_SLOT_EVERY + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fb_state_e;

  // WORDS_PER_LINE is a power of two, so line*WORDS_PER_LINE + word is a plain
  // concatenation; the result is cut down to the RAM address width.
  function automatic logic [ADDR_W-1:0] line_word_addr(input logic [LINE_W-1:0] line,
                                                       input logic [WORD_W-1:0] word);
    logic [LINE_W+WORD_W-1:0] full;
    full = {line, word};
    return ADDR_W'(full);
  endfunction

endpackage

// File: rtl/mac_se_fb_fetch_ctr.sv
// Line/word position counter for the display-line fetch.
// Ports:
//   clk_in, reset   pixel clock, synchronous active-high reset
//   load            start a new line: capture line_in, word index back to 0
//   advance         step to the next word (ignored when load is high)
//   line_in         line number to fetch
//   addr            RAM word address of the current position
//   word            current word index within the line
//   last            current word is the final word of the line
module mac_se_fb_fetch_ctr
  import mac_se_fb_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [LINE_W-1:0] line_in,
  output logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] word,
  output logic              last
);

  logic [LINE_W-1:0] line;

  // A load always wins over advance so a restarted fetch begins cleanly at word 0.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      line <= '0;
      word <= '0;
    end else if (load) begin
      line <= line_in;
      word <= '0;
    end else if (advance) begin
      word <= word + 1'b1;
    end
  end

  assign addr = line_word_addr(line, word);
  assign last = (word == WORD_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/mac_se_fb_arbiter.sv
// Single-port frame-buffer RAM arbiter between the capture writer and the
// display line fetcher. A fetch request streams one line of words out of RAM;
// capture writes use idle cycles and a guaranteed slot after every
// WR_SLOT_EVERY fetch reads.
// Optional build macro: FB_ARB_STATS_EN adds the stat_overruns and
// stat_wr_stalls saturating counters.
// Ports:
//   clk_in, reset            pixel clock, synchronous active-high reset
//   wr_valid/wr_ready        capture write handshake, wr_addr/wr_data payload
//   fetch_req/fetch_line     one-cycle line fetch request
//   fetch_busy               fetch reads still to be issued
//   fetch_overrun            request arrived while a fetch was still issuing
//   rd_valid/rd_data/rd_word fetched word stream, fetch_done on the last word
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  RAM port, 1-cycle read latency
//   stat_overruns/stat_wr_stalls  (FB_ARB_STATS_EN only) event counters
module mac_se_fb_arbiter
  import mac_se_fb_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fetch_req,
  input  logic [LINE_W-1:0] fetch_line,
  output logic              fetch_busy,
  output logic              fetch_overrun,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [WORD_W-1:0] rd_word,
  output logic              fetch_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]       stat_overruns,
  output logic [15:0]       stat_wr_stalls
`endif
);

  localparam logic [LINE_W-1:0] LINES_LIMIT = LINE_W'(FB_LINES);
  localparam logic [RUN_W-1:0]  SLOT_RUN    = RUN_W'(WR_SLOT_EVERY);

  fb_state_e         state, state_next;
  logic [RUN_W-1:0]  rd_run;
  logic              req_ok, slot_due;
  logic              ctr_load, ctr_advance, ctr_last;
  logic [ADDR_W-1:0] ctr_addr;
  logic [WORD_W-1:0] ctr_word;
  logic              rd_issue, run_clear, run_inc;

  mac_se_fb_fetch_ctr u_fetch_ctr (
    .clk_in  (clk_in),
    .reset   (reset),
    .load    (ctr_load),
    .advance (ctr_advance),
    .line_in (fetch_line),
    .addr    (ctr_addr),
    .word    (ctr_word),
    .last    (ctr_last)
  );

  // Requests for lines beyond the visible frame are dropped outright.
  assign req_ok     = fetch_req && (fetch_line < LINES_LIMIT);
  assign slot_due   = (rd_run >= SLOT_RUN);
  assign fetch_busy = (state == FETCH);
  assign rd_data    = ram_rdata;

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A due write slot stays due until a write actually uses it. A request that
  // lands on the final read issue starts the next line without counting as
  // an overrun, since nothing of the old line is lost.
  always_comb begin
    state_next    = state;
    wr_ready      = 1'b0;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    ctr_load      = 1'b0;
    ctr_advance   = 1'b0;
    rd_issue      = 1'b0;
    run_clear     = 1'b0;
    run_inc       = 1'b0;
    fetch_overrun = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
        end
        if (req_ok) begin
          ctr_load   = 1'b1;
          run_clear  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        wr_ready = slot_due;
        if (slot_due && wr_valid) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
          run_clear = 1'b1;
        end else begin
          ram_en      = 1'b1;
          ram_addr    = ctr_addr;
          rd_issue    = 1'b1;
          ctr_advance = 1'b1;
          run_inc     = 1'b1;
          if (ctr_last) state_next = IDLE;
        end
        if (req_ok) begin
          ctr_load      = 1'b1;
          run_clear     = 1'b1;
          state_next    = FETCH;
          fetch_overrun = !(rd_issue && ctr_last);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reads issued since the last write slot; capped once a slot is due.
  always_ff @(posedge clk_in) begin
    if (reset || run_clear) rd_run <= '0;
    else if (run_inc && !slot_due) rd_run <= rd_run + 1'b1;
  end

  // Read-return pipeline aligned to the RAM latency; a read abandoned by an
  // overrun never shows up as valid data.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      rd_word    <= '0;
      fetch_done <= 1'b0;
    end else begin
      rd_valid   <= rd_issue && !fetch_overrun;
      rd_word    <= ctr_word;
      fetch_done <= rd_issue && ctr_last && !fetch_overrun;
    end
  end

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk_in) begin
    if (reset) begin
      stat_overruns  <= '0;
      stat_wr_stalls <= '0;
    end else begin
      if (fetch_overrun && stat_overruns != 16'hFFFF)
        stat_overruns <= stat_overruns + 16'd1;
      if (wr_valid && !wr_ready && stat_wr_stalls != 16'hFFFF)
        stat_wr_stalls <= stat_wr_stalls + 16'd1;
    end
  end
`endif

endmodule
